// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master sequencing single-word RAM writes and reads
//
// Purpose: accepts one request at a time and serialises it into a 10-bit
// address frame {cmd, addr} and a 10-bit data frame {cmd, data}. Reads then
// idle for RD_WAIT cycles and shift ADDR_SIZE bits in from MISO.
// Optional feature macro: SPI_CTRL_ADDR_CACHE_EN. When it is defined, the
// address frame and its gap are skipped when the address matches the last
// address sent for that operation type.
//
// Ports:
//   clk, rst               system/SPI bit clock, synchronous active-high reset
//   req_valid, req_ready   request handshake (ready only in IDLE)
//   req_rd                 1 = read, 0 = write
//   req_addr, req_wdata    request address and write data
//   rsp_valid, rsp_rdata   one-cycle completion pulse and held read data
//   SS_n, MOSI, MISO       SPI slave select (active low) and serial data
`timescale 1ns/1ps
module spi_master_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int RD_WAIT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rd,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [ADDR_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [ADDR_SIZE-1:0] rsp_rdata,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);
    localparam int FRAME = ADDR_SIZE + 2;
    localparam int CW    = ADDR_SIZE - 1;
    localparam logic [3:0] SHIFT_LAST = 4'(ADDR_SIZE + 1);
    localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
    localparam logic [3:0] CAP_LAST   = 4'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT_A, S_GAP, S_SHIFT_D, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    state_t               state, state_next;
    logic [3:0]           cnt;
    logic [FRAME-1:0]     shreg;
    logic                 rd_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [CW-1:0]        cap;
    logic                 accept, hit, load_a, load_d, ss_n_next;
    logic                 d_rd;
    logic [ADDR_SIZE-1:0] d_wdata;
    logic [FRAME-1:0]     data_frame;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    // MOSI is the MSB of the frame register; it shifts in zeros, so MOSI is 0 in GAP/WAIT/DONE
    assign MOSI      = shreg[FRAME-1];

    // A data frame can be loaded straight from the request (cache hit) or from the latched copy
    assign d_rd       = (state == S_IDLE) ? req_rd : rd_q;
    assign d_wdata    = (state == S_IDLE) ? req_wdata : wdata_q;
    assign data_frame = {d_rd, 1'b1, (d_rd ? {ADDR_SIZE{1'b0}} : d_wdata)};

`ifdef SPI_CTRL_ADDR_CACHE_EN
    logic                 wc_valid, rc_valid;
    logic [ADDR_SIZE-1:0] wc_addr, rc_addr;

    assign hit = req_rd ? (rc_valid && rc_addr == req_addr)
                        : (wc_valid && wc_addr == req_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_valid <= 1'b0;
            rc_valid <= 1'b0;
            wc_addr  <= '0;
            rc_addr  <= '0;
        end else if (accept && !hit) begin
            if (req_rd) begin
                rc_valid <= 1'b1;
                rc_addr  <= req_addr;
            end else begin
                wc_valid <= 1'b1;
                wc_addr  <= req_addr;
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_d     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (hit) begin
                        state_next = S_SHIFT_D;
                        load_d     = 1'b1;
                    end else begin
                        state_next = S_SHIFT_A;
                        load_a     = 1'b1;
                    end
                end
            end
            S_SHIFT_A: if (cnt == SHIFT_LAST) state_next = S_GAP;
            S_GAP: begin
                state_next = S_SHIFT_D;
                load_d     = 1'b1;
            end
            S_SHIFT_D: if (cnt == SHIFT_LAST) state_next = rd_q ? S_WAIT : S_DONE;
            S_WAIT:    if (cnt == WAIT_LAST) state_next = S_CAPTURE;
            S_CAPTURE: if (cnt == CAP_LAST) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        // SS_n is registered, so it follows the state being entered
        ss_n_next = !(state_next inside {S_SHIFT_A, S_SHIFT_D, S_WAIT, S_CAPTURE});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            shreg     <= '0;
            rd_q      <= 1'b0;
            wdata_q   <= '0;
            cap       <= '0;
            SS_n      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? 4'd0 : cnt + 4'd1;
            if (load_a) begin
                shreg <= {req_rd, 1'b0, req_addr};
            end else if (load_d) begin
                shreg <= data_frame;
            end else begin
                shreg <= {shreg[FRAME-2:0], 1'b0};
            end
            if (accept) begin
                rd_q    <= req_rd;
                wdata_q <= req_wdata;
            end
            if (state == S_CAPTURE) begin
                cap <= CW'({cap, MISO});
            end
            SS_n      <= ss_n_next;
            rsp_valid <= (state_next == S_DONE);
            // The last MISO bit is folded in directly so the data is ready with rsp_valid
            if (state_next == S_DONE) begin
                rsp_rdata <= (state == S_CAPTURE) ? {cap, MISO} : '0;
            end
        end
    end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Host-side SPI master controller that sequences single-word write and read transactions into the SPI slave/RAM subsystem. It accepts one request at a time over a valid/ready handshake, serialises each into two 10-bit frames (address frame, then data frame), drives `SS_n`/`MOSI`, and for reads captures the returned word from `MISO`. It sits between a host bus adapter and the SPI wrapper, sharing the wrapper's `clk`.

## Interface
- `ADDR_SIZE`, 8: address and data word width; frame length is `ADDR_SIZE+2`.
- `RD_WAIT`, 2: idle `MOSI` cycles between the end of a read-data frame and the first `MISO` sample (1..15).
- `clk`  in  1  system clock; also the SPI bit clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_rd`  in  1  1 = read, 0 = write.
- `req_addr`  in  ADDR_SIZE  RAM address.
- `req_wdata`  in  ADDR_SIZE  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  ADDR_SIZE  read data; 0 on write completion; held until next `rsp_valid`.
- `SS_n`  out  1  slave select, active low.
- `MOSI`  out  1  serial data to slave, MSB first.
- `MISO`  in  1  serial data from slave, MSB first.

## Operation
- Frame = `{cmd[1:0], payload[ADDR_SIZE-1:0]}`, shifted MSB first, one bit per `clk`, `SS_n` low for the whole frame.
- cmd encoding: 00 write address, 01 write data, 10 read address, 11 read data (payload 0).
- Write op: frame `{00,req_addr}`, then `{01,req_wdata}`.
- Read op: frame `{10,req_addr}`, then `{11,0}`, then `RD_WAIT` cycles with `SS_n` low, `MOSI`=0, then `ADDR_SIZE` cycles sampling `MISO` into a shift register; `SS_n` rises after the last sample.
- States: IDLE -> (accept) SHIFT_A -> GAP -> SHIFT_D -> {write: DONE | read: WAIT -> CAPTURE -> DONE} -> IDLE.
- GAP: one cycle `SS_n`=1 between frames. DONE: `SS_n`=1, `rsp_valid`=1, one cycle.
- Request fields latched on acceptance; later changes on inputs have no effect.
- Bit counter 4 bits; SHIFT ends when counter reaches `ADDR_SIZE+1`; WAIT ends at `RD_WAIT-1`; CAPTURE ends at `ADDR_SIZE-1`.
- Reset (any state, including mid-frame): next cycle IDLE, `SS_n`=1, `MOSI`=0, `rsp_valid`=0, `rsp_rdata`=0, counters 0, address cache invalid; aborted transaction produces no response.
- Reset values: `SS_n`=1, `MOSI`=0, `rsp_valid`=0, `rsp_rdata`=0, `req_ready`=1 once `rst` deasserts.

## Timing
- `req_ready` = (state==IDLE); accept when `req_valid && req_ready` at edge T.
- First address bit on `MOSI` with `SS_n`=0 at cycle T+1; address frame T+1..T+10 (ADDR_SIZE=8); GAP T+11; data frame T+12..T+21.
- Write: `rsp_valid` at T+22, `req_ready` at T+23.
- Read (RD_WAIT=2): WAIT T+22..T+23, samples T+24..T+31 (first sample = bit 7), `rsp_valid` with data at T+32, `req_ready` at T+33.
- `MOSI`, `SS_n` registered; `MISO` sampled on the rising `clk` edge ending each CAPTURE cycle.
- `req_valid` held high in DONE is not accepted until the following IDLE cycle.

## Configuration
- `SPI_CTRL_ADDR_CACHE_EN` defined: controller keeps the last write address and last read address sent (each with a valid bit). A write to the cached write address, or a read from the cached read address, skips the address frame and its GAP, starting directly with the data frame at T+1 (write `rsp_valid` at T+11). Cache entries invalidated by reset.
- Undefined: every operation sends both frames; no cache registers.

## Test plan
- Reset then write addr 0x3C data 0xA5 -> `MOSI` sequence 00_0011_1100, GAP, 01_1010_0101; `rsp_valid` at T+22, `rsp_rdata`=0.
- Write 0x3C←0xA5, then read 0x3C with slave model -> read frames 10_0011_1100 / 11_0000_0000, `rsp_rdata`=0xA5 at T+32.
- `req_valid` held high continuously with back-to-back writes -> `req_ready` only in IDLE, exactly one GAP/DONE between ops, no dropped request.
- Assert `rst` at bit 5 of a read's data frame -> next cycle `SS_n`=1, `MOSI`=0, no `rsp_valid`; a new read after release completes correctly.
- With `SPI_CTRL_ADDR_CACHE_EN`: two writes to 0x10 -> second op sends only `{01,data}`, `rsp_valid` at T+11; then write 0x11 -> full two-frame sequence.
- `RD_WAIT`=4, read returning 0x81 -> first sample at T+26, `rsp_rdata`=0x81 at T+34.
